data_mem_ctrl: RTL and testbench

Request/response controller sitting directly upstream of the 128×16 data memory. It accepts one load or store per transaction from the datapath over a valid/ready handshake and drives the memory's address, data, write-enable and read-enable strobes. It captures load data into a register and returns the result over a second valid/ready handshake. It also keeps saturating load/store counters for debug.

---
 rtl/data_mem_ctrl.sv | 168 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
//
// Request/response controller placed in front of the data memory. It takes
// one load or store per transaction over a valid/ready request handshake,
// drives the memory strobes for exactly one cycle, registers load data, and
// returns the result over a valid/ready response handshake. It also keeps
// saturating debug counters of completed loads and stores.
//
// Optional feature macro: DATA_MEM_CTRL_BOUNDS_CHK_EN
//   defined     : a latched address >= MEM_DEPTH is rejected. No memory
//                 strobe is issued, and the response has resp_err=1 and
//                 resp_rdata=0.
//   not defined : the address is truncated to log2(MEM_DEPTH) bits and
//                 wraps. resp_err is always 0.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/req_ready request handshake
//   req_we              1 = store, 0 = load
//   req_addr, req_wdata request word address and store data
//   resp_valid/resp_ready response handshake
//   resp_rdata          load data; 0 for stores and errors
//   resp_err            request rejected (out of range)
//   datamem_addr        memory address
//   datamem_data        memory write data
//   we, re              memory write and read strobes
//   datamem_strm        memory read data, combinational from the memory
//   load_cnt, store_cnt saturating completed-transaction counters
// ---------------------------------------------------------------------------
module data_mem_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] datamem_addr,
  output logic [DATA_W-1:0] datamem_data,
  output logic              we,
  output logic              re,
  input  logic [DATA_W-1:0] datamem_strm,
  output logic [15:0]       load_cnt,
  output logic [15:0]       store_cnt
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic              we_lat_reg;
  logic [ADDR_W-1:0] addr_lat_reg;
  logic [DATA_W-1:0] wdata_lat_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              err_reg;
  logic [15:0]       load_cnt_reg;
  logic [15:0]       store_cnt_reg;

  logic              addr_err;
  logic [ADDR_W-1:0] eff_addr;

`ifdef DATA_MEM_CTRL_BOUNDS_CHK_EN
  // The comparison is done one bit wider so that a MEM_DEPTH equal to
  // 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_L = MEM_DEPTH[ADDR_W:0];

  assign addr_err = ({1'b0, addr_lat_reg} >= DEPTH_L);
  assign eff_addr = addr_lat_reg;
`else
  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'((64'd1 << MEM_AW) - 64'd1);

  // Upper address bits are discarded on purpose so that the address wraps.
  logic unused_addr_bits;
  assign unused_addr_bits = ^(addr_lat_reg & ~ADDR_MASK);

  assign addr_err = 1'b0;
  assign eff_addr = addr_lat_reg & ADDR_MASK;
`endif

  // Next-state logic
  always_comb begin
    state_next = ST_IDLE;
    case (state_reg)
      ST_IDLE:   state_next = req_valid ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: state_next = ST_RESP;
      ST_RESP:   state_next = resp_ready ? ST_IDLE : ST_RESP;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Memory strobes. These are only active in ACCESS and are suppressed on a
  // range error. Everything is 0 otherwise, so the memory sees a quiet bus.
  always_comb begin
    datamem_addr = '0;
    datamem_data = '0;
    we           = 1'b0;
    re           = 1'b0;
    if ((state_reg == ST_ACCESS) && !addr_err) begin
      datamem_addr = eff_addr;
      if (we_lat_reg) begin
        we           = 1'b1;
        datamem_data = wdata_lat_reg;
      end else begin
        re = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      we_lat_reg    <= 1'b0;
      addr_lat_reg  <= '0;
      wdata_lat_reg <= '0;
      rdata_reg     <= '0;
      err_reg       <= 1'b0;
      load_cnt_reg  <= '0;
      store_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            we_lat_reg    <= req_we;
            addr_lat_reg  <= req_addr;
            wdata_lat_reg <= req_wdata;
          end
        end
        ST_ACCESS: begin
          // Memory read data is combinational, so capture it on the edge
          // that ends ACCESS. Stores and errors return 0.
          err_reg   <= addr_err;
          rdata_reg <= (!we_lat_reg && !addr_err) ? datamem_strm : '0;
        end
        ST_RESP: begin
          if (resp_ready && !err_reg) begin
            if (we_lat_reg) begin
              if (store_cnt_reg != 16'hFFFF) store_cnt_reg <= store_cnt_reg + 16'd1;
            end else begin
              if (load_cnt_reg != 16'hFFFF) load_cnt_reg <= load_cnt_reg + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state_reg == ST_IDLE);
  assign resp_valid = (state_reg == ST_RESP);
  assign resp_rdata = rdata_reg;
  assign resp_err   = err_reg;
  assign load_cnt   = load_cnt_reg;
  assign store_cnt  = store_cnt_reg;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_mem_ctrl
//
// Directed testbench for data_mem_ctrl. A behavioural memory with a
// combinational read and a write on the clock edge sits behind the DUT.
// Inputs change 1 time unit after the rising edge, and outputs are sampled
// at that same point or partway through a cycle around a reset.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_mem_ctrl;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int MEM_DEPTH = 128;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] datamem_addr;
  logic [DATA_W-1:0] datamem_data;
  logic              we;
  logic              re;
  logic [DATA_W-1:0] datamem_strm;
  logic [15:0]       load_cnt;
  logic [15:0]       store_cnt;

  int errors = 0;
  int checks = 0;

  data_mem_ctrl #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MEM_DEPTH(MEM_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .datamem_addr(datamem_addr),
    .datamem_data(datamem_data),
    .we          (we),
    .re          (re),
    .datamem_strm(datamem_strm),
    .load_cnt    (load_cnt),
    .store_cnt   (store_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural memory
  logic [DATA_W-1:0] mem [0:65535];
  assign datamem_strm = mem[datamem_addr];
  always @(posedge clk) begin
    if (we) mem[datamem_addr] <= datamem_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Setup-only transaction with resp_ready held 1. It contains no checks.
  task automatic run_txn(input logic w, input logic [15:0] a, input logic [15:0] d);
    req_valid  = 1'b1;
    req_we     = w;
    req_addr   = a;
    req_wdata  = d;
    resp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    // Start a store, then hit reset while it is in ACCESS.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'd3; req_wdata = 16'h3333;
    tick();
    req_valid = 1'b0;
    checks++;
    if (we !== 1'b1) begin errors++; $display("FAIL reset_pre_we: got %b want 1", we); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, resp_valid, we, re, resp_err} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: got rr/rv/we/re/err=%b want 10000",
               {req_ready, resp_valid, we, re, resp_err});
    end
    checks++;
    if ({datamem_addr, datamem_data, resp_rdata} !== 48'd0) begin
      errors++;
      $display("FAIL reset_buses: got addr=%h data=%h rdata=%h want 0", datamem_addr, datamem_data, resp_rdata);
    end
    checks++;
    if ({load_cnt, store_cnt} !== 32'd0) begin
      errors++;
      $display("FAIL reset_cnt: got load=%0d store=%0d want 0", load_cnt, store_cnt);
    end
    @(negedge clk) rst = 1'b0;
    tick();
  endtask

  task automatic test_store_load();
    resp_ready = 1'b1;
    checks++;
    if (we !== 1'b0) begin errors++; $display("FAIL sl_we_idle: got %b want 0", we); end
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'd5; req_wdata = 16'hA5A5;
    tick();                     // accept edge
    req_valid = 1'b0;
    checks++;
    if ({we, re, req_ready} !== 3'b100 || datamem_addr !== 16'd5 || datamem_data !== 16'hA5A5) begin
      errors++;
      $display("FAIL st_access: got we/re/rr=%b addr=%0d data=%h want 100 addr=5 data=a5a5",
               {we, re, req_ready}, datamem_addr, datamem_data);
    end
    tick();
    checks++;
    if (we !== 1'b0 || resp_valid !== 1'b1 || resp_rdata !== 16'h0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL st_resp: got we=%b rv=%b rdata=%h err=%b want 0 1 0000 0", we, resp_valid, resp_rdata, resp_err);
    end
    tick();                     // handshake edge
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || store_cnt !== 16'd1 || load_cnt !== 16'd0) begin
      errors++;
      $display("FAIL st_done: got rv=%b rr=%b store=%0d load=%0d want 0 1 1 0", resp_valid, req_ready, store_cnt, load_cnt);
    end
    // Load the same word back.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'd5;
    tick();
    req_valid = 1'b0;
    checks++;
    if ({we, re} !== 2'b01 || datamem_addr !== 16'd5 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL ld_access: got we/re=%b addr=%0d rv=%b want 01 addr=5 rv=0", {we, re}, datamem_addr, resp_valid);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 16'hA5A5) begin
      errors++;
      $display("FAIL ld_resp: got rv=%b rdata=%h want 1 a5a5", resp_valid, resp_rdata);
    end
    tick();
    checks++;
    if (load_cnt !== 16'd1 || store_cnt !== 16'd1 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ld_done: got load=%0d store=%0d rr=%b want 1 1 1", load_cnt, store_cnt, req_ready);
    end
  endtask

  task automatic test_stall();
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'd5;
    tick();
    // Keep req_valid high with a different request. It must not be taken.
    req_we = 1'b1; req_addr = 16'd9; req_wdata = 16'hDEAD;
    tick();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 16'hA5A5 || req_ready !== 1'b0 ||
          {we, re} !== 2'b00 || load_cnt !== 16'd1) begin
        errors++;
        $display("FAIL stall_%0d: got rv=%b rdata=%h rr=%b we/re=%b load=%0d want 1 a5a5 0 00 1",
                 i, resp_valid, resp_rdata, req_ready, {we, re}, load_cnt);
      end
      tick();
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    tick();                     // the single handshake
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || load_cnt !== 16'd2 || store_cnt !== 16'd1) begin
      errors++;
      $display("FAIL stall_release: got rr=%b rv=%b load=%0d store=%0d want 1 0 2 1", req_ready, resp_valid, load_cnt, store_cnt);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b0 || load_cnt !== 16'd2 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_once: got rv=%b load=%0d rr=%b want 0 2 1", resp_valid, load_cnt, req_ready);
    end
  endtask

  task automatic test_out_of_range();
    run_txn(1'b1, 16'd72, 16'h7272);   // store_cnt -> 2
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'd200;
    tick();
    req_valid = 1'b0;
`ifdef DATA_MEM_CTRL_BOUNDS_CHK_EN
    checks++;
    if ({we, re} !== 2'b00) begin errors++; $display("FAIL oor_strobe: got we/re=%b want 00", {we, re}); end
    tick();
    checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 16'h0) begin
      errors++;
      $display("FAIL oor_resp: got rv=%b err=%b rdata=%h want 1 1 0000", resp_valid, resp_err, resp_rdata);
    end
    tick();
    checks++;
    if (load_cnt !== 16'd2 || store_cnt !== 16'd2) begin
      errors++;
      $display("FAIL oor_cnt: got load=%0d store=%0d want 2 2", load_cnt, store_cnt);
    end
`else
    checks++;
    if ({we, re} !== 2'b01 || datamem_addr !== 16'd72) begin
      errors++;
      $display("FAIL wrap_access: got we/re=%b addr=%0d want 01 addr=72", {we, re}, datamem_addr);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 16'h7272) begin
      errors++;
      $display("FAIL wrap_resp: got rv=%b err=%b rdata=%h want 1 0 7272", resp_valid, resp_err, resp_rdata);
    end
    tick();
    checks++;
    if (load_cnt !== 16'd3 || store_cnt !== 16'd2) begin
      errors++;
      $display("FAIL wrap_cnt: got load=%0d store=%0d want 3 2", load_cnt, store_cnt);
    end
`endif
  endtask

  task automatic test_saturation();
    logic [15:0] load_before;
    load_before = load_cnt;
    force dut.store_cnt_reg = 16'hFFFE;
    #1;
    release dut.store_cnt_reg;
    run_txn(1'b1, 16'd10, 16'h0001);
    checks++;
    if (store_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h want ffff", store_cnt); end
    run_txn(1'b1, 16'd11, 16'h0002);
    checks++;
    if (store_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold1: got %h want ffff", store_cnt); end
    run_txn(1'b1, 16'd12, 16'h0003);
    checks++;
    if (store_cnt !== 16'hFFFF || load_cnt !== load_before) begin
      errors++;
      $display("FAIL sat_hold2: got store=%h load=%0d want ffff %0d", store_cnt, load_cnt, load_before);
    end
  endtask

  task automatic test_reset_mid();
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'd5;
    tick();
    req_valid = 1'b0;
    tick();
    checks++;
    if (resp_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre: got rv=%b want 1", resp_valid); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 16'h0 ||
        load_cnt !== 16'd0 || store_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rmid_reset: got rv=%b rr=%b rdata=%h load=%0d store=%0d want 0 1 0000 0 0",
               resp_valid, req_ready, resp_rdata, load_cnt, store_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'd11; req_wdata = 16'h0BEE;
    tick();                     // first edge with req_valid must accept
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    checks++;
    if (we !== 1'b1 || datamem_addr !== 16'd11 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rmid_accept: got we=%b addr=%0d rr=%b want 1 11 0", we, datamem_addr, req_ready);
    end
    tick();
    tick();
    checks++;
    if (store_cnt !== 16'd1 || load_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rmid_cnt: got store=%0d load=%0d want 1 0", store_cnt, load_cnt);
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;
    test_reset();
    test_store_load();
    test_stall();
    test_out_of_range();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
